// File: rtl/fir_pkg.sv
// Shared constants, state encoding and bank-select helper for the 40-tap FIR sequencer.
package fir_pkg;

  localparam int CLK_DIV       = 20;
  localparam int TAPS_PER_BANK = 10;
  localparam int NUM_BANKS     = 4;
  localparam int ADDR_W        = 4;
  localparam int COEF_W        = 16;
  localparam int TOTAL_TAPS    = NUM_BANKS * TAPS_PER_BANK;
  localparam int DIV_W         = $clog2(CLK_DIV);
  localparam int BANK_W        = $clog2(NUM_BANKS);

  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(TAPS_PER_BANK - 1);
  localparam logic [BANK_W-1:0]    LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [NUM_BANKS-1:0] ALL_BANKS = {NUM_BANKS{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    MAC   = 3'd2,
    SUM   = 3'd3,
    DONE  = 3'd4,
    LOAD  = 3'd5
  } firState_e;

  function automatic logic [NUM_BANKS-1:0] bankOneHot(input logic [BANK_W-1:0] idx);
    logic [NUM_BANKS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fir_controller_strobe.sv
// Free-running sample divider; terminal count is registered so it lines up with count = CLK_DIV-1.
module sample_strobe_gen
  import fir_pkg::*;
(
  input  logic iClk12M,
  input  logic iRst,
  output logic oTermCnt
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] CNT_PRE  = DIV_W'(CLK_DIV - 2);

  logic [DIV_W-1:0] divCntR;

  // Divider counter and terminal-count flag.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      divCntR  <= '0;
      oTermCnt <= 1'b0;
    end else begin
      if (divCntR == CNT_LAST) begin
        divCntR <= '0;
      end else begin
        divCntR <= divCntR + DIV_W'(1);
      end
      oTermCnt <= (divCntR == CNT_PRE);
    end
  end

endmodule

// File: rtl/fir_controller.sv
// Sequencer for the FIR datapath: sample strobe, shift/MAC/sum sequence, and host coefficient load.
module fir_controller
  import fir_pkg::*;
(
  input  logic                 iClk12M,
  input  logic                 iRst,
  input  logic                 iCoeffUpdateFlag,
  input  logic                 iCoeffWr,
  input  logic [COEF_W-1:0]    iCoeffData,
  output logic                 oEnSample600k,
  output logic                 oEnDelay,
  output logic [NUM_BANKS-1:0] oBankEn,
  output logic                 oBankWr,
  output logic [ADDR_W-1:0]    oAddr,
  output logic [COEF_W-1:0]    oWrData,
  output logic                 oMacClr,
  output logic                 oEnMac,
  output logic                 oEnAdd,
  output logic                 oFirValid,
  output logic                 oLoadDone
);

  firState_e         stateR;
  logic [ADDR_W-1:0] tapCntR;
  logic [ADDR_W-1:0] wrAddrR;
  logic [BANK_W-1:0] wrBankR;
  logic              allWrittenR;
  logic              termCntS;
  logic              writeOkS;
  logic              lastWrS;

  sample_strobe_gen uStrobe (
    .iClk12M  (iClk12M),
    .iRst     (iRst),
    .oTermCnt (termCntS)
  );

  // The strobe is only offered while idle in filter mode, so a busy or loading FSM never sees it.
  assign oEnSample600k = termCntS && (stateR == IDLE) && !iCoeffUpdateFlag;
  assign writeOkS      = iCoeffWr && !allWrittenR;
  assign lastWrS       = (wrBankR == LAST_BANK) && (wrAddrR == LAST_ADDR);

  // Sequencer FSM; every output is registered and set on the transition into the state that owns it.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      stateR      <= IDLE;
      tapCntR     <= '0;
      wrAddrR     <= '0;
      wrBankR     <= '0;
      allWrittenR <= 1'b0;
      oEnDelay    <= 1'b0;
      oMacClr     <= 1'b0;
      oEnMac      <= 1'b0;
      oEnAdd      <= 1'b0;
      oFirValid   <= 1'b0;
      oBankEn     <= '0;
      oBankWr     <= 1'b0;
      oAddr       <= '0;
      oWrData     <= '0;
      oLoadDone   <= 1'b0;
    end else begin
      oEnDelay  <= 1'b0;
      oMacClr   <= 1'b0;
      oEnMac    <= 1'b0;
      oEnAdd    <= 1'b0;
      oFirValid <= 1'b0;
      oBankEn   <= '0;
      oBankWr   <= 1'b0;
      oAddr     <= '0;
      oWrData   <= '0;
      oLoadDone <= 1'b0;

      case (stateR)
        IDLE: begin
          if (iCoeffUpdateFlag) begin
            stateR <= LOAD;
          end else if (oEnSample600k) begin
            stateR   <= SHIFT;
            oEnDelay <= 1'b1;
            oMacClr  <= 1'b1;
          end else begin
            stateR <= IDLE;
          end
        end

        SHIFT: begin
          stateR  <= MAC;
          tapCntR <= '0;
          oEnMac  <= 1'b1;
          oBankEn <= ALL_BANKS;
          oAddr   <= '0;
        end

        MAC: begin
          if (tapCntR == LAST_ADDR) begin
            stateR  <= SUM;
            tapCntR <= '0;
            oEnAdd  <= 1'b1;
          end else begin
            tapCntR <= tapCntR + ADDR_W'(1);
            oEnMac  <= 1'b1;
            oBankEn <= ALL_BANKS;
            oAddr   <= tapCntR + ADDR_W'(1);
          end
        end

        SUM: begin
          stateR    <= DONE;
          oFirValid <= 1'b1;
        end

        DONE: begin
          stateR <= IDLE;
        end

        LOAD: begin
          if (writeOkS) begin
            oBankEn <= bankOneHot(wrBankR);
            oAddr   <= wrAddrR;
            oBankWr <= 1'b1;
            oWrData <= iCoeffData;
            if (wrAddrR == LAST_ADDR) begin
              wrAddrR <= '0;
              wrBankR <= wrBankR + BANK_W'(1);
            end else begin
              wrAddrR <= wrAddrR + ADDR_W'(1);
            end
            allWrittenR <= lastWrS;
          end else begin
            allWrittenR <= allWrittenR;
          end
          // Leaving update mode still honours a same-cycle write, but the index restarts.
          if (!iCoeffUpdateFlag) begin
            stateR      <= IDLE;
            wrAddrR     <= '0;
            wrBankR     <= '0;
            allWrittenR <= 1'b0;
            oLoadDone   <= 1'b0;
          end else begin
            stateR    <= LOAD;
            oLoadDone <= allWrittenR;
          end
        end

        default: begin
          stateR <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller: filter timing, coefficient load, mode changes and reset abort.
module tb_fir_controller;
  import fir_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag;
  logic        wr;
  logic [15:0] wrIn;
  logic        enSample, enDelay, bankWr, macClr, enMac, enAdd, firValid, loadDone;
  logic [3:0]  bankEn;
  logic [3:0]  addr;
  logic [15:0] wrData;

  int errCnt   = 0;
  int checkCnt = 0;

  fir_controller dut (
    .iClk12M          (clk),
    .iRst             (rst),
    .iCoeffUpdateFlag (flag),
    .iCoeffWr         (wr),
    .iCoeffData       (wrIn),
    .oEnSample600k    (enSample),
    .oEnDelay         (enDelay),
    .oBankEn          (bankEn),
    .oBankWr          (bankWr),
    .oAddr            (addr),
    .oWrData          (wrData),
    .oMacClr          (macClr),
    .oEnMac           (enMac),
    .oEnAdd           (enAdd),
    .oFirValid        (firValid),
    .oLoadDone        (loadDone)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic s, input logic dl, input logic mc, input logic em,
                                     input logic [3:0] be, input logic bw, input logic [3:0] ad,
                                     input logic ea, input logic fv, input logic ld,
                                     input logic [15:0] wd);
    return {s, dl, mc, em, be, bw, ad, ea, fv, ld, wd};
  endfunction

  function automatic logic [31:0] obs();
    return {enSample, enDelay, macClr, enMac, bankEn, bankWr, addr, enAdd, firValid, loadDone, wrData};
  endfunction

  // Expected outputs d cycles after a sample strobe.
  function automatic logic [31:0] seqExp(input int d);
    logic [3:0] a;
    a = 4'(d - 2);
    if (d == 0)                 return mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    else if (d == 1)            return mk(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    else if (d >= 2 && d <= 11) return mk(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, a,    1'b0, 1'b0, 1'b0, 16'h0);
    else if (d == 12)           return mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    else if (d == 13)           return mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    else                        return 32'h0;
  endfunction

  function automatic logic [31:0] wrExp(input int idx, input logic [15:0] d);
    logic [3:0] one;
    one = 4'b0001;
    return mk(1'b0, 1'b0, 1'b0, 1'b0, one << (idx / 10), 1'b1, 4'(idx % 10), 1'b0, 1'b0, 1'b0, d);
  endfunction

  localparam logic [31:0] NO_STROBE = 32'h7FFF_FFFF;

  initial begin
    int   lastT;
    logic found;

    rst  = 1'b1;
    flag = 1'b0;
    wr   = 1'b0;
    wrIn = 16'h0;
    tick;
    tick;
    checkEq("resetHold", obs(), 32'h0);
    rst = 1'b0;

    // Filter mode, stray writes, then update flag raised at SHIFT+3 of the strobe at 99.
    lastT = -100;
    for (int c = 0; c <= 125; c++) begin
      if (c % 20 == 19 && c <= 99) lastT = c;
      checkEq($sformatf("filt%0d", c), obs(), seqExp(c - lastT));
      wr   = (c < 100) && (c % 7 == 3);
      wrIn = 16'hDEAD;
      if (c == 103) flag = 1'b1;
      tick;
    end

    // Full back-to-back coefficient load.
    for (int i = 0; i < 40; i++) begin
      wr   = 1'b1;
      wrIn = 16'(i + 256);
      tick;
      checkEq($sformatf("load%0d", i), obs() & NO_STROBE, wrExp(i, 16'(i + 256)));
    end
    wr = 1'b0;
    tick;
    checkEq("loadDone", obs() & NO_STROBE,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0));
    wr   = 1'b1;
    wrIn = 16'hBEEF;
    tick;
    wr = 1'b0;
    checkEq("write41", obs() & NO_STROBE,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0));

    // Drop and re-raise the flag, 15 writes, drop on the last write, re-enter and write once.
    flag = 1'b0;
    tick;
    checkEq("loadDoneClr", {31'h0, loadDone}, 32'h0);
    flag = 1'b1;
    tick;
    for (int i = 0; i < 15; i++) begin
      wr   = 1'b1;
      wrIn = 16'(i + 256);
      if (i == 14) flag = 1'b0;
      tick;
      checkEq($sformatf("part%0d", i), obs() & NO_STROBE, wrExp(i, 16'(i + 256)));
    end
    wr   = 1'b0;
    flag = 1'b1;
    tick;
    wr   = 1'b1;
    wrIn = 16'h0ABC;
    tick;
    wr = 1'b0;
    checkEq("restart", obs() & NO_STROBE, wrExp(0, 16'h0ABC));

    // Back to filter mode, then reset in the middle of the MAC phase.
    flag  = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick;
      if (enSample) found = 1'b1;
    end
    checkEq("strobeWait", {31'h0, found}, 32'h1);
    for (int k = 1; k <= 6; k++) tick;
    checkEq("midMac", obs(), seqExp(6));
    rst = 1'b1;
    tick;
    checkEq("rstAbort", obs(), 32'h0);
    rst = 1'b0;
    for (int j = 1; j <= 21; j++) begin
      tick;
      checkEq($sformatf("postRst%0d", j), obs(), seqExp(j - 19));
    end

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
